// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants for the instruction fetch front end.
//   FPQ_DATA_WIDTH  : instruction word and address width
//   FPQ_RESET_PC    : default first fetch address after reset
//   FPQ_INSTR_BYTES : byte stride between sequential fetch addresses
package fetch_prefetch_queue_pkg;

  localparam int FPQ_DATA_WIDTH = 32;
  localparam logic [FPQ_DATA_WIDTH-1:0] FPQ_RESET_PC = 32'h0000_0000;
  localparam int FPQ_INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO holding {instruction, address} entries for the
// prefetch queue.
//   clk, reset   : clock, asynchronous active-low reset (pointers/count only)
//   clear        : synchronous discard of all entries
//   push/push_data : enqueue request and payload
//   pop          : dequeue the head entry (ignored when empty)
//   head_data    : oldest entry, meaningful only when count != 0
//   count        : current occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PW bits wide, so they wrap modulo DEPTH for free.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; entries are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetcher with a credit-based
// request stream, in-order cache responses, a prefetch queue, and redirect /
// flush handling that discards responses of abandoned fetches.
//   clk, reset                : clock, asynchronous active-low reset
//   stall                     : decode not ready, head entry is held
//   flush                     : discard queue, replay from oldest unconsumed address
//   exception / handler addr  : highest-priority redirect
//   branch / branch_target    : redirect below exception
//   cache_req_valid/addr/ready: fetch request handshake
//   cache_valid / cache_in    : in-order response stream
//   instruction_*_out         : queue head, its address, address+4, non-empty flag
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = FPQ_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(FPQ_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exception,
  input  logic [DATA_WIDTH-1:0] exception_handler_address,
  input  logic                  branch,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic                  cache_req_valid,
  output logic [DATA_WIDTH-1:0] cache_req_addr,
  input  logic                  cache_req_ready,
  input  logic                  cache_valid,
  input  logic [DATA_WIDTH-1:0] cache_in,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic [DATA_WIDTH-1:0] instruction_address_out,
  output logic [DATA_WIDTH-1:0] pc_plus_4_out,
  output logic                  instruction_valid_out
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW1-1:0]        CREDIT_LIMIT = CW1'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] STEP         = DATA_WIDTH'(FPQ_INSTR_BYTES);

  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
    return {a[DATA_WIDTH-1:2], 2'b00};
  endfunction

  logic [DATA_WIDTH-1:0]   fetch_pc;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           drop_cnt;
  logic [CW-1:0]           occupancy;
  logic [CW-1:0]           live;
  logic [CW-1:0]           outstanding_nxt;
  logic [DATA_WIDTH-1:0]   oldest_live_addr;
  logic [DATA_WIDTH-1:0]   flush_pc;
  logic [2*DATA_WIDTH-1:0] head_entry;
  logic [DATA_WIDTH-1:0]   head_addr;
  logic                    redirect;
  logic                    action;
  logic                    handshake;
  logic                    resp_taken;
  logic                    resp_drop;
  logic                    push;
  logic                    pop;

  assign redirect = exception | branch;
  assign action   = redirect | flush;

  // Credits cover both queued entries and fetches still in flight, so every
  // response always has a free slot waiting for it.
  assign cache_req_valid = reset && !action &&
                           (({1'b0, occupancy} + {1'b0, outstanding}) < CREDIT_LIMIT);
  assign cache_req_addr  = fetch_pc;
  assign handshake       = cache_req_valid && cache_req_ready;

  // A response with nothing outstanding is spurious and ignored entirely.
  assign resp_taken = cache_valid && (outstanding != '0);
  assign resp_drop  = resp_taken && ((drop_cnt != '0) || action);
  assign push       = resp_taken && !resp_drop;

  assign instruction_valid_out = (occupancy != '0);
  assign pop                   = instruction_valid_out && !stall;

  // Responses still worth keeping were requested sequentially since the last
  // redirect, ending just below fetch_pc; the oldest of them owns this response.
  assign live             = outstanding - drop_cnt;
  assign oldest_live_addr = fetch_pc - DATA_WIDTH'({live, 2'b00});
  assign outstanding_nxt  = outstanding + CW'(handshake) - CW'(resp_taken);

  // Replay point: head of queue, else oldest live fetch, else where we were.
  always_comb begin
    flush_pc = fetch_pc;
    if (instruction_valid_out) flush_pc = head_addr;
    else if (live != '0)       flush_pc = oldest_live_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (exception) begin
        fetch_pc <= word_align(exception_handler_address);
        drop_cnt <= outstanding_nxt;
      end else if (branch) begin
        fetch_pc <= word_align(branch_target);
        drop_cnt <= outstanding_nxt;
      end else if (flush) begin
        fetch_pc <= flush_pc;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + STEP;
        if (resp_taken && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (action),
    .push      (push),
    .push_data ({cache_in, oldest_live_addr}),
    .pop       (pop),
    .head_data (head_entry),
    .count     (occupancy)
  );

  assign head_addr               = head_entry[DATA_WIDTH-1:0];
  assign instruction_out         = instruction_valid_out ? head_entry[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign instruction_address_out = instruction_valid_out ? head_addr : '0;
  assign pc_plus_4_out           = instruction_valid_out ? head_addr + STEP : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, exception, branch;
  logic [31:0] exception_handler_address, branch_target;
  logic        cache_req_valid, cache_req_ready, cache_valid, instruction_valid_out;
  logic [31:0] cache_req_addr, cache_in, instruction_out, instruction_address_out, pc_plus_4_out;

  int checks   = 0;
  int failures = 0;

  fetch_prefetch_queue #(
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .stall                     (stall),
    .flush                     (flush),
    .exception                 (exception),
    .exception_handler_address (exception_handler_address),
    .branch                    (branch),
    .branch_target             (branch_target),
    .cache_req_valid           (cache_req_valid),
    .cache_req_addr            (cache_req_addr),
    .cache_req_ready           (cache_req_ready),
    .cache_valid               (cache_valid),
    .cache_in                  (cache_in),
    .instruction_out           (instruction_out),
    .instruction_address_out   (instruction_address_out),
    .pc_plus_4_out             (pc_plus_4_out),
    .instruction_valid_out     (instruction_valid_out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  // ---------------- cache responder: 1-cycle in-order responses ----------------
  logic        resp_hold;
  logic        hs_n;
  logic [31:0] hs_addr_n;
  logic [31:0] pend[$];
  int          hs_total = 0;
  logic [31:0] last_req_addr = 32'h0;
  logic        cv_q;
  logic [31:0] cd_q;

  assign cache_valid = cv_q && !resp_hold;
  assign cache_in    = cd_q;

  always @(negedge clk) begin
    hs_n      = cache_req_valid && cache_req_ready;
    hs_addr_n = cache_req_addr;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend.delete();
      cv_q <= 1'b0;
      cd_q <= 32'h0;
    end else begin
      if (cache_valid && pend.size() > 0) void'(pend.pop_front());
      if (hs_n) begin
        pend.push_back(hs_addr_n);
        hs_total++;
        last_req_addr = hs_addr_n;
      end
      cv_q <= (pend.size() > 0);
      cd_q <= (pend.size() > 0) ? data_of(pend[0]) : 32'h0;
    end
  end

  // ---------------- reference model: queues of entries and in-flight fetches ----------------
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] addr; } ent_t;

  req_t        m_out[$];
  ent_t        m_q[$];
  logic [31:0] m_pc;
  req_t        r;
  ent_t        e;
  logic [31:0] ftgt;
  bit          m_act, m_hs, found;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_out.delete();
      m_pc = RESET_PC;
    end else begin
      m_act = exception || branch || flush;
      m_hs  = !m_act && (m_q.size() + m_out.size() < DEPTH) && cache_req_ready;
      ftgt  = m_pc;
      if (m_q.size() > 0) ftgt = m_q[0].addr;
      else begin
        found = 0;
        for (int i = 0; i < m_out.size(); i++)
          if (!found && !m_out[i].stale) begin ftgt = m_out[i].addr; found = 1; end
      end
      if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
      if (cache_valid && m_out.size() > 0) begin
        r = m_out.pop_front();
        if (!r.stale && !m_act) begin
          e.instr = cache_in;
          e.addr  = r.addr;
          m_q.push_back(e);
        end
      end
      if (m_act) begin
        m_q.delete();
        for (int i = 0; i < m_out.size(); i++) m_out[i].stale = 1'b1;
        if (exception)   m_pc = exception_handler_address & 32'hFFFF_FFFC;
        else if (branch) m_pc = branch_target & 32'hFFFF_FFFC;
        else             m_pc = ftgt;
      end else if (m_hs) begin
        r.addr  = m_pc;
        r.stale = 1'b0;
        m_out.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit exp_v;
  always @(negedge clk) begin
    if (reset) begin
      exp_v = !(exception || branch || flush) && (m_q.size() + m_out.size() < DEPTH);
      check("m_req_valid", {31'd0, cache_req_valid}, {31'd0, exp_v});
      if (exp_v) check("m_req_addr", cache_req_addr, m_pc);
      check("m_instr_valid", {31'd0, instruction_valid_out}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) begin
        check("m_instr", instruction_out, m_q[0].instr);
        check("m_addr", instruction_address_out, m_q[0].addr);
        check("m_pc4", pc_plus_4_out, m_q[0].addr + 32'd4);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_head(input string name, input int lim);
    int n = 0;
    @(negedge clk);
    while (!instruction_valid_out && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, instruction_valid_out}, 32'd1);
  endtask

  int base;

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; exception = 1'b0; branch = 1'b0;
    exception_handler_address = 32'h0; branch_target = 32'h0;
    cache_req_ready = 1'b1; resp_hold = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_valid", {31'd0, cache_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instruction_valid_out}, 32'd0);
    check("rst_instr", instruction_out, 32'h0);
    check("rst_addr", instruction_address_out, 32'h0);
    check("rst_pc4", pc_plus_4_out, 32'h0);
    tick(); tick();
    reset = 1'b1;

    // Basic stream: responses 1, 2 at addresses 0x0, 0x4
    wait_head("a_head_wait", 10);
    check("a_addr0", instruction_address_out, 32'h0);
    check("a_instr0", instruction_out, 32'h1);
    check("a_pc4_0", pc_plus_4_out, 32'h4);
    @(negedge clk);
    check("a_addr1", instruction_address_out, 32'h4);
    check("a_instr1", instruction_out, 32'h2);
    check("a_pc4_1", pc_plus_4_out, 32'h8);
    repeat (3) tick();

    // Mid-run reset, then stall held: credit allows exactly DEPTH requests
    reset = 1'b0; stall = 1'b1;
    tick(); tick();
    reset = 1'b1;
    base = hs_total;
    repeat (10) tick();
    @(negedge clk);
    check("b_req_count", 32'(hs_total - base), 32'd4);
    check("b_last_req", last_req_addr, 32'hC);
    check("b_req_valid", {31'd0, cache_req_valid}, 32'd0);
    check("b_head_addr", instruction_address_out, 32'h0);

    // Drain two entries with no new fetches, then flush with {0x8, 0xC} queued
    tick(); cache_req_ready = 1'b0; stall = 1'b0;
    tick(); tick(); stall = 1'b1;
    @(negedge clk);
    check("c_head_before", instruction_address_out, 32'h8);
    tick(); flush = 1'b1; cache_req_ready = 1'b1;
    @(negedge clk);
    check("c_flush_req_valid", {31'd0, cache_req_valid}, 32'd0);
    tick(); flush = 1'b0; resp_hold = 1'b1;
    @(negedge clk);
    check("c_empty", {31'd0, instruction_valid_out}, 32'd0);
    check("c_refetch_valid", {31'd0, cache_req_valid}, 32'd1);
    check("c_refetch_addr", cache_req_addr, 32'h8);

    // Two outstanding (0x8, 0xC), branch to 0x1002
    tick();
    tick(); cache_req_ready = 1'b0;
    tick(); branch = 1'b1; branch_target = 32'h0000_1002; cache_req_ready = 1'b1; resp_hold = 1'b0;
    @(negedge clk);
    check("d_branch_req_valid", {31'd0, cache_req_valid}, 32'd0);
    tick(); branch = 1'b0;
    @(negedge clk);
    check("d_req_valid", {31'd0, cache_req_valid}, 32'd1);
    check("d_req_addr", cache_req_addr, 32'h1000);
    wait_head("d_head_wait", 10);
    check("d_first_addr", instruction_address_out, 32'h1000);
    check("d_first_instr", instruction_out, 32'h401);
    repeat (8) tick();

    // Exception beats branch in the same cycle
    exception = 1'b1; branch = 1'b1;
    exception_handler_address = 32'h0000_2000; branch_target = 32'h0000_3000;
    tick(); exception = 1'b0; branch = 1'b0;
    @(negedge clk);
    check("e_req_addr", cache_req_addr, 32'h2000);
    repeat (8) tick();

    // Queue at full credit (3 queued + 1 in flight): response lands on a pop
    cache_req_ready = 1'b0; stall = 1'b0;
    tick(); stall = 1'b1; cache_req_ready = 1'b1; resp_hold = 1'b1;
    tick(); cache_req_ready = 1'b0;
    tick(); stall = 1'b0; resp_hold = 1'b0;
    @(negedge clk);
    check("f_head0", instruction_address_out, 32'h2004);
    @(negedge clk);
    check("f_head1", instruction_address_out, 32'h2008);
    @(negedge clk);
    check("f_head2", instruction_address_out, 32'h200C);
    @(negedge clk);
    check("f_head3", instruction_address_out, 32'h2010);
    check("f_instr3", instruction_out, 32'h805);
    @(negedge clk);
    check("f_drained", {31'd0, instruction_valid_out}, 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), instruction and address width.
REQ-002 Parameter DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  decode not ready; head entry held.
REQ-007 flush  input  1  discard queue and in-flight fetches; replay from oldest unconsumed address.
REQ-008 exception  input  1  redirect to exception_handler_address.
REQ-009 exception_handler_address  input  DATA_WIDTH  exception redirect target.
REQ-010 branch  input  1  redirect to branch_target.
REQ-011 branch_target  input  DATA_WIDTH  branch redirect target.
REQ-012 cache_req_valid  output  1  fetch request valid.
REQ-013 cache_req_addr  output  DATA_WIDTH  fetch request address.
REQ-014 cache_req_ready  input  1  cache accepts request this cycle.
REQ-015 cache_valid  input  1  in-order response valid.
REQ-016 cache_in  input  DATA_WIDTH  response instruction word.
REQ-017 instruction_out  output  DATA_WIDTH  head instruction.
REQ-018 instruction_address_out  output  DATA_WIDTH  head instruction address.
REQ-019 pc_plus_4_out  output  DATA_WIDTH  instruction_address_out + 4, modulo 2^DATA_WIDTH.
REQ-020 instruction_valid_out  output  1  queue non-empty.

Function
REQ-021 Request handshake completes on a cycle with cache_req_valid=1 and cache_req_ready=1; fetch PC advances by 4 on that edge.
REQ-022 cache_req_valid SHALL be 1 only when occupancy + outstanding < DEPTH and no redirect/flush is asserted that cycle.
REQ-023 Responses return in request order; each non-dropped response enqueues {cache_in, address} on the clock edge; visible at outputs the following cycle (min. latency response-to-output 1 cycle).
REQ-024 Head pops on an edge where instruction_valid_out=1 and stall=0; push and pop in the same cycle are both performed.
REQ-025 Credit rule guarantees no overflow; a response arriving with no outstanding request is ignored.
REQ-026 Priority: exception > branch > flush; one action per cycle.
REQ-027 Redirect (exception or branch): queue emptied, fetch PC loaded with target, low 2 bits forced to 0, drop counter loaded with current outstanding count (after this cycle's response).
REQ-028 Flush alone: queue emptied, fetch PC loaded with head instruction_address_out if queue non-empty, else address of oldest outstanding request, else unchanged fetch PC; drop counter loaded as in REQ-027.
REQ-029 While drop counter > 0, each cache_valid decrements it and the response is discarded.
REQ-030 A response arriving in the same cycle as a redirect/flush is discarded and not counted in the drop counter.
REQ-031 stall does not block fetching; requests continue until credit exhausted.
REQ-032 Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-033 On reset low: fetch PC=RESET_PC, queue empty, outstanding=0, drop counter=0, cache_req_valid=0, instruction_valid_out=0, instruction_out/instruction_address_out/pc_plus_4_out=0.
REQ-034 First request issued the first cycle after reset deasserts; reset mid-operation discards all state and in-flight responses are not dropped-counted.

Structure
REQ-035 DATA_WIDTH and default RESET_PC SHALL live in the shared sabit_veriler.vh constants header.
REQ-036 Queue storage SHALL be one sub-module fetch_fifo (DEPTH x 2*DATA_WIDTH synchronous FIFO, count output); credit, PC, redirect and drop logic stay in fetch_prefetch_queue.

Verification
REQ-037 Reset release, cache_req_ready=1, 1-cycle responses 32'h00000001,32'h00000002 -> outputs addr 0x0 then 0x4, pc_plus_4_out 0x4 then 0x8.
REQ-038 stall=1 held, DEPTH=4 -> exactly 4 requests issued (0x0..0xC), cache_req_valid drops to 0, head stays addr 0x0.
REQ-039 Two outstanding, branch=1 target 32'h00001002 -> next request addr 0x1000, both stale responses discarded, first output addr 0x1000.
REQ-040 exception=1 and branch=1 same cycle, handler 32'h00002000 -> next request 0x2000.
REQ-041 Queue holds addrs 0x8,0xC, flush=1 -> queue empty, refetch starts at 0x8.
REQ-042 Full queue, stall=0, response same cycle as pop -> occupancy unchanged, no data loss, order preserved.
